// File: rtl/pc_stack_sequencer.sv
// -----------------------------------------------------------------------------
// pc_stack_sequencer
//   Instruction fetch sequencer for the program ROM. Holds the program counter,
//   the instruction register and a circular hardware call stack. Applies the
//   decoder's GOTO / CALL / RETURN / skip requests. Every taken redirect or skip
//   inserts exactly one bubble into the instruction register.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   rom_data  instruction word read combinationally from ROM at rom_addr
//   stall     hold PC, IR, stack and flags; all requests ignored
//   goto_en   branch to target
//   call_en   push return address (current PC) and branch to target
//   ret_en    pop top of stack into PC
//   skip_en   discard the word currently being fetched
//   target    branch / call destination
//   rom_addr  current PC, i.e. the address fetched this cycle
//   ir        instruction executing this cycle
//   ir_valid  ir holds a real instruction (0 = bubble)
//   sp        stack pointer, next free slot
//   stk_ovf   sticky: push while the stack was full
//   stk_unf   sticky: pop while the stack was empty
// -----------------------------------------------------------------------------
module pc_stack_sequencer #(
  parameter int unsigned            ADDR_W      = 11,
  parameter int unsigned            DATA_W      = 14,
  parameter int unsigned            STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]      RESET_VEC   = 11'h000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              rom_data,
  input  logic                           stall,
  input  logic                           goto_en,
  input  logic                           call_en,
  input  logic                           ret_en,
  input  logic                           skip_en,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              rom_addr,
  output logic [DATA_W-1:0]              ir,
  output logic                           ir_valid,
  output logic [$clog2(STACK_DEPTH)-1:0] sp,
  output logic                           stk_ovf,
  output logic                           stk_unf
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH);

  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);
  localparam logic [SP_W-1:0]   SP_ONE     = SP_W'(1);
  localparam logic [SP_W:0]     DEPTH_ONE  = (SP_W+1)'(1);
  localparam logic [SP_W:0]     DEPTH_ZERO = (SP_W+1)'(0);
  localparam logic [SP_W:0]     DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);
  localparam logic [DATA_W-1:0] IR_NOP     = {DATA_W{1'b0}};

  // Single-bit encoding so ir_valid is the state flop itself.
  typedef enum logic [0:0] {
    ST_BUBBLE = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [DATA_W-1:0] ir_r, ir_nxt_s;
  logic [SP_W-1:0]   sp_r, sp_nxt_s;
  logic [SP_W:0]     depth_r, depth_nxt_s;
  logic              ovf_r, ovf_nxt_s;
  logic              unf_r, unf_nxt_s;
  logic              push_s;
  logic [SP_W-1:0]   pop_idx_s;
  logic [ADDR_W-1:0] stack_r [STACK_DEPTH];

  // Top-of-stack slot; wraps naturally when the pointer is zero.
  assign pop_idx_s = sp_r - SP_ONE;

  // Next-state and datapath decode, prioritised stall > ret > call > goto > skip > run.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    sp_nxt_s    = sp_r;
    depth_nxt_s = depth_r;
    ovf_nxt_s   = ovf_r;
    unf_nxt_s   = unf_r;
    push_s      = 1'b0;

    if (stall) begin
      // Everything holds at its default value.
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_BUBBLE: begin
          // Requests are only meaningful while a real instruction executes.
          pc_nxt_s    = pc_r + PC_ONE;
          ir_nxt_s    = rom_data;
          state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          if (ret_en) begin
            pc_nxt_s    = stack_r[pop_idx_s];
            sp_nxt_s    = pop_idx_s;
            ir_nxt_s    = IR_NOP;
            state_nxt_s = ST_BUBBLE;
            if (depth_r == DEPTH_ZERO) begin
              unf_nxt_s = 1'b1;
            end else begin
              depth_nxt_s = depth_r - DEPTH_ONE;
            end
          end else if (call_en) begin
            push_s      = 1'b1;
            pc_nxt_s    = target;
            sp_nxt_s    = sp_r + SP_ONE;
            ir_nxt_s    = IR_NOP;
            state_nxt_s = ST_BUBBLE;
            // A full stack overwrites its oldest entry; depth stays saturated.
            if (depth_r == DEPTH_FULL) begin
              ovf_nxt_s = 1'b1;
            end else begin
              depth_nxt_s = depth_r + DEPTH_ONE;
            end
          end else if (goto_en) begin
            pc_nxt_s    = target;
            ir_nxt_s    = IR_NOP;
            state_nxt_s = ST_BUBBLE;
          end else if (skip_en) begin
            pc_nxt_s    = pc_r + PC_ONE;
            ir_nxt_s    = IR_NOP;
            state_nxt_s = ST_BUBBLE;
          end else begin
            pc_nxt_s    = pc_r + PC_ONE;
            ir_nxt_s    = rom_data;
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          pc_nxt_s    = pc_r;
          ir_nxt_s    = IR_NOP;
          state_nxt_s = ST_BUBBLE;
        end
      endcase
    end
  end

  // Control and datapath registers; reset overrides any concurrent request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BUBBLE;
      pc_r    <= RESET_VEC;
      ir_r    <= IR_NOP;
      sp_r    <= {SP_W{1'b0}};
      depth_r <= DEPTH_ZERO;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      sp_r    <= sp_nxt_s;
      depth_r <= depth_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  // Call stack storage; cleared on reset so an empty pop returns a known value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      stack_r[sp_r] <= pc_r;
    end else begin
      stack_r[sp_r] <= stack_r[sp_r];
    end
  end

  assign rom_addr = pc_r;
  assign ir       = ir_r;
  assign ir_valid = (state_r == ST_RUN);
  assign sp       = sp_r;
  assign stk_ovf  = ovf_r;
  assign stk_unf  = unf_r;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_stack_sequencer
//   Directed stimulus for pc_stack_sequencer. The driver pushes the hand-derived
//   post-edge state for every cycle it drives into a queue; the monitor pops one
//   entry per falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pc_stack_sequencer;

  logic        clk;
  logic        rst;
  logic [13:0] rom_data;
  logic        stall;
  logic        goto_en;
  logic        call_en;
  logic        ret_en;
  logic        skip_en;
  logic [10:0] target;
  logic [10:0] rom_addr;
  logic [13:0] ir;
  logic        ir_valid;
  logic [2:0]  sp;
  logic        stk_ovf;
  logic        stk_unf;

  typedef struct {
    logic [10:0] pc;
    logic        v;
    logic [13:0] ir;
    logic [2:0]  sp;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   mon_idx;
  logic stim_done;

  // control vector order: {rst, stall, ret, call, goto, skip}
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b100000;
  localparam logic [5:0] C_STALL = 6'b010000;
  localparam logic [5:0] C_RET   = 6'b001000;
  localparam logic [5:0] C_CALL  = 6'b000100;
  localparam logic [5:0] C_GOTO  = 6'b000010;
  localparam logic [5:0] C_SKIP  = 6'b000001;

  // ROM image: two fixed words, the rest tagged with their own address.
  function automatic logic [13:0] rw(input logic [10:0] a);
    if (a == 11'h000) return 14'h3005;
    else if (a == 11'h001) return 14'h00A5;
    else return {3'b101, a};
  endfunction

  assign rom_data = rw(rom_addr);

  pc_stack_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .rom_data (rom_data),
    .stall    (stall),
    .goto_en  (goto_en),
    .call_en  (call_en),
    .ret_en   (ret_en),
    .skip_en  (skip_en),
    .target   (target),
    .rom_addr (rom_addr),
    .ir       (ir),
    .ir_valid (ir_valid),
    .sp       (sp),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [5:0] ctl, input logic [10:0] tgt,
                      input logic [10:0] e_pc, input logic e_v, input logic [13:0] e_ir,
                      input logic [2:0] e_sp, input logic e_ovf, input logic e_unf);
    exp_t e;
    @(negedge clk);
    {rst, stall, ret_en, call_en, goto_en, skip_en} = ctl;
    target = tgt;
    @(posedge clk);
    e.pc = e_pc; e.v = e_v; e.ir = e_ir; e.sp = e_sp; e.ovf = e_ovf; e.unf = e_unf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [10:0] e_pc, input logic [13:0] e_ir,
                      input logic [2:0] e_sp, input logic e_ovf, input logic e_unf);
    step(C_IDLE, 11'h000, e_pc, 1'b1, e_ir, e_sp, e_ovf, e_unf);
  endtask

  task automatic redirect(input logic [5:0] ctl, input logic [10:0] tgt, input logic [10:0] e_pc,
                          input logic [2:0] e_sp, input logic e_ovf, input logic e_unf);
    step(ctl, tgt, e_pc, 1'b0, 14'h0000, e_sp, e_ovf, e_unf);
  endtask

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h want %0h", nm, mon_idx, act, want);
    end
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rom_addr", int'(rom_addr), int'(e.pc));
      chk("ir_valid", int'(ir_valid), int'(e.v));
      chk("ir",       int'(ir),       int'(e.ir));
      chk("sp",       int'(sp),       int'(e.sp));
      chk("stk_ovf",  int'(stk_ovf),  int'(e.ovf));
      chk("stk_unf",  int'(stk_unf),  int'(e.unf));
      mon_idx++;
    end
    if (stim_done && exp_q.size() == 0) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] tgt;
    logic [10:0] pa;
    checks = 0; errors = 0; mon_idx = 0; stim_done = 1'b0;
    rst = 1'b1; stall = 1'b0; ret_en = 1'b0; call_en = 1'b0;
    goto_en = 1'b0; skip_en = 1'b0; target = 11'h000;

    // Reset, then fetch from the reset vector after one bubble.
    step(C_RST, 11'h000, 11'h000, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0);
    idle(11'h001, 14'h3005, 3'd0, 1'b0, 1'b0);
    idle(11'h002, 14'h00A5, 3'd0, 1'b0, 1'b0);
    for (int p = 2; p < 11; p++) idle(11'(p + 1), rw(11'(p)), 3'd0, 1'b0, 1'b0);

    // CALL at 0x00B to 0x00C and RETURN back to 0x00B.
    redirect(C_CALL, 11'h00C, 11'h00C, 3'd1, 1'b0, 1'b0);
    idle(11'h00D, rw(11'h00C), 3'd1, 1'b0, 1'b0);
    redirect(C_RET, 11'h000, 11'h00B, 3'd0, 1'b0, 1'b0);
    idle(11'h00C, rw(11'h00B), 3'd0, 1'b0, 1'b0);
    for (int p = 12; p < 18; p++) idle(11'(p + 1), rw(11'(p)), 3'd0, 1'b0, 1'b0);

    // GOTO 0x010 from 0x012, then SKIP at 0x011.
    redirect(C_GOTO, 11'h010, 11'h010, 3'd0, 1'b0, 1'b0);
    idle(11'h011, rw(11'h010), 3'd0, 1'b0, 1'b0);
    redirect(C_SKIP, 11'h000, 11'h012, 3'd0, 1'b0, 1'b0);
    // GOTO during the bubble is ignored.
    step(C_GOTO, 11'h100, 11'h013, 1'b1, rw(11'h012), 3'd0, 1'b0, 1'b0);
    // Stall three cycles with a CALL pending: nothing moves.
    for (int k = 0; k < 3; k++)
      step(C_STALL | C_CALL, 11'h055, 11'h013, 1'b1, rw(11'h012), 3'd0, 1'b0, 1'b0);
    idle(11'h014, rw(11'h013), 3'd0, 1'b0, 1'b0);

    // Nine nested calls: the ninth overflows and sp wraps to 1.
    for (int i = 0; i < 9; i++) begin
      tgt = 11'h100 + 11'(16 * i);
      redirect(C_CALL, tgt, tgt, 3'(i + 1), (i == 8), 1'b0);
      idle(tgt + 11'd1, rw(tgt), 3'(i + 1), (i == 8), 1'b0);
    end

    // Nine returns: the oldest frame (0x014) was overwritten; the ninth underflows.
    for (int j = 0; j < 9; j++) begin
      pa = (j == 8) ? 11'h171 : 11'h171 - 11'(16 * j);
      redirect(C_RET, 11'h000, pa, 3'(8 - j), 1'b1, (j == 8));
      idle(pa + 11'd1, rw(pa), 3'(8 - j), 1'b1, (j == 8));
    end

    // PC wraps from 0x7FF to 0x000 with no flag.
    redirect(C_GOTO, 11'h7FE, 11'h7FE, 3'd0, 1'b1, 1'b1);
    idle(11'h7FF, rw(11'h7FE), 3'd0, 1'b1, 1'b1);
    idle(11'h000, rw(11'h7FF), 3'd0, 1'b1, 1'b1);
    idle(11'h001, 14'h3005, 3'd0, 1'b1, 1'b1);

    // Reset during a bubble with CALL asserted: no push, flags cleared.
    redirect(C_CALL, 11'h020, 11'h020, 3'd1, 1'b1, 1'b1);
    step(C_RST | C_CALL, 11'h055, 11'h000, 1'b0, 14'h0000, 3'd0, 1'b0, 1'b0);
    idle(11'h001, 14'h3005, 3'd0, 1'b0, 1'b0);
    idle(11'h002, 14'h00A5, 3'd0, 1'b0, 1'b0);

    stim_done = 1'b1;
  end

endmodule
